// File: rtl/median_filter_stream_adapter_if.sv
// median_filter_stream_adapter_if: input pixel stream, output pixel stream and unit memory port of the adapter.
// Signals: s_* input stream (pix/valid/ready/last), m_* output stream (pix/valid/ready/last),
// dina/addra/wea/ena/douta the memory-mapped port of median_filter_unit ({mode, addr} addressing).
// Modports: master = adapter side, slave = pixel source/sink and unit side.
interface median_filter_stream_adapter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18,
    parameter int MODE_W = 2
);
    logic [7:0]               s_pix_i;
    logic                     s_valid_i;
    logic                     s_ready_o;
    logic                     s_last_i;
    logic [7:0]               m_pix_o;
    logic                     m_valid_o;
    logic                     m_ready_i;
    logic                     m_last_o;
    logic [DATA_W-1:0]        dina_o;
    logic [MODE_W+ADDR_W-1:0] addra_o;
    logic                     wea_o;
    logic                     ena_o;
    logic [DATA_W-1:0]        douta_i;
    modport master (
        input  s_pix_i, s_valid_i, s_last_i, m_ready_i, douta_i,
        output s_ready_o, m_pix_o, m_valid_o, m_last_o, dina_o, addra_o, wea_o, ena_o
    );
    modport slave (
        output s_pix_i, s_valid_i, s_last_i, m_ready_i, douta_i,
        input  s_ready_o, m_pix_o, m_valid_o, m_last_o, dina_o, addra_o, wea_o, ena_o
    );
endinterface

// File: rtl/median_filter_stream_adapter.sv
// median_filter_stream_adapter: loads a streamed frame into median_filter_unit, configures and starts it, polls for completion and streams the filtered frame out.
// Ports: CLK clock; RST async active-low reset; start_i latches cfg_width_i/cfg_height_i in IDLE;
// busy_o high outside IDLE; done_o one-cycle pulse after the last output pixel; err_o sticky frame error;
// bus (master modport) carries the input stream, the output stream and the unit's registered memory port.
// Optional feature: define MEDIAN_ADAPTER_FRAME_CHECK_EN to reject bad frame sizes and misplaced s_last_i.
module median_filter_stream_adapter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 18,
    parameter int MODE_W   = 2,
    parameter int READ_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_i,
    input  logic [15:0] cfg_width_i,
    input  logic [15:0] cfg_height_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    median_filter_stream_adapter_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, CFG_W, CFG_H, START, POLL, DRAIN, DONE} state_t;
    localparam int PW = $clog2(READ_LAT + 2) + 1;
    localparam logic [PW-1:0] POLL_GO = PW'(READ_LAT + 1);
    state_t            state;
    logic [15:0]       w, h;
    logic [ADDR_W-1:0] last, idx, rd_idx, out_idx;
    logic              rd_all;
    logic [PW-1:0]     poll_cnt;
    logic [READ_LAT:0] rd_pipe;
    logic [7:0]        fifo [4];
    logic [1:0]        wp, rp;
    logic [2:0]        occ;
    logic [31:0]       prod;
    logic              accept, push, pop, issue, hit, bad_size, bad_beat;

    assign prod   = 32'(cfg_width_i) * 32'(cfg_height_i);
    assign accept = state == LOAD && bus.s_valid_i;
    assign push   = rd_pipe[READ_LAT];
    assign pop    = bus.m_valid_o && bus.m_ready_i;
    // reads still in flight reserve FIFO space, so backpressure can never overflow it
    assign issue  = state == DRAIN && !rd_all && (32'(occ) + 32'($countones(rd_pipe)) < 32'd4);
    // the first READ_LAT+1 poll cycles carry no valid read data yet
    assign hit    = poll_cnt == POLL_GO && bus.douta_i == DATA_W'(1);
`ifdef MEDIAN_ADAPTER_FRAME_CHECK_EN
    assign bad_size = prod == 32'd0 || prod > (32'd1 << ADDR_W);
    assign bad_beat = accept && (bus.s_last_i != (idx == last));
`else
    assign bad_size = 1'b0;
    assign bad_beat = 1'b0;
`endif

    assign busy_o        = state != IDLE;
    assign done_o        = state == DONE;
    assign bus.s_ready_o = state == LOAD;
    assign bus.m_valid_o = occ != 3'd0;
    assign bus.m_pix_o   = fifo[rp];
    assign bus.m_last_o  = bus.m_valid_o && state == DRAIN && out_idx == last;

    always_ff @(posedge CLK) begin
        if (push) fifo[wp] <= bus.douta_i[7:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            w           <= '0;
            h           <= '0;
            last        <= '0;
            idx         <= '0;
            rd_idx      <= '0;
            out_idx     <= '0;
            rd_all      <= 1'b0;
            poll_cnt    <= '0;
            rd_pipe     <= '0;
            wp          <= '0;
            rp          <= '0;
            occ         <= '0;
            err_o       <= 1'b0;
            bus.dina_o  <= '0;
            bus.addra_o <= '0;
            bus.wea_o   <= 1'b0;
            bus.ena_o   <= 1'b0;
        end else begin
            bus.wea_o <= 1'b0;
            bus.ena_o <= 1'b0;
            rd_pipe   <= (rd_pipe << 1) | (READ_LAT + 1)'(issue);
            occ       <= occ + 3'(push) - 3'(pop);
            if (push) wp <= wp + 2'd1;
            if (pop) rp <= rp + 2'd1;
            case (state)
                IDLE: if (start_i) begin
                    w        <= cfg_width_i;
                    h        <= cfg_height_i;
                    last     <= ADDR_W'(prod - 32'd1);
                    idx      <= '0;
                    rd_idx   <= '0;
                    out_idx  <= '0;
                    rd_all   <= 1'b0;
                    poll_cnt <= '0;
                    err_o    <= bad_size;
                    state    <= bad_size ? IDLE : LOAD;
                end
                LOAD: if (accept) begin
                    bus.addra_o <= {MODE_W'(0), idx};
                    bus.dina_o  <= DATA_W'(bus.s_pix_i);
                    bus.wea_o   <= 1'b1;
                    bus.ena_o   <= 1'b1;
                    idx         <= idx + 1'b1;
                    if (bad_beat) err_o <= 1'b1;
                    state <= bad_beat ? IDLE : idx == last ? CFG_W : LOAD;
                end
                CFG_W: begin
                    bus.addra_o <= {MODE_W'(2), ADDR_W'(0)};
                    bus.dina_o  <= DATA_W'(w);
                    bus.wea_o   <= 1'b1;
                    bus.ena_o   <= 1'b1;
                    state       <= CFG_H;
                end
                CFG_H: begin
                    bus.addra_o <= {MODE_W'(3), ADDR_W'(0)};
                    bus.dina_o  <= DATA_W'(h);
                    bus.wea_o   <= 1'b1;
                    bus.ena_o   <= 1'b1;
                    state       <= START;
                end
                START: begin
                    bus.addra_o <= {MODE_W'(1), ADDR_W'(0)};
                    bus.dina_o  <= DATA_W'(1);
                    bus.wea_o   <= 1'b1;
                    bus.ena_o   <= 1'b1;
                    state       <= POLL;
                end
                POLL: if (hit) begin
                    state <= DRAIN;
                end else begin
                    bus.addra_o <= {MODE_W'(1), ADDR_W'(0)};
                    bus.ena_o   <= 1'b1;
                    if (poll_cnt != POLL_GO) poll_cnt <= poll_cnt + 1'b1;
                end
                DRAIN: begin
                    if (issue) begin
                        bus.addra_o <= {MODE_W'(0), rd_idx};
                        bus.ena_o   <= 1'b1;
                        rd_idx      <= rd_idx + 1'b1;
                        if (rd_idx == last) rd_all <= 1'b1;
                    end
                    if (pop) begin
                        out_idx <= out_idx + 1'b1;
                        if (out_idx == last) state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_median_filter_stream_adapter.sv
// tb_median_filter_stream_adapter: directed bench with a behavioural median_filter_unit model and an output scoreboard.
module tb_median_filter_stream_adapter;
    localparam int DATA_W = 32, ADDR_W = 18, MODE_W = 2, READ_LAT = 1;
    logic        CLK = 1'b0, RST = 1'b0, start_i = 1'b0;
    logic [15:0] cfg_width_i = '0, cfg_height_i = '0;
    logic        busy_o, done_o, err_o;
    median_filter_stream_adapter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MODE_W(MODE_W)) bus ();
    median_filter_stream_adapter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MODE_W(MODE_W), .READ_LAT(READ_LAT)) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .bus(bus)
    );
    always #5 CLK = ~CLK;

    int tests = 0, fails = 0;
    logic [7:0] exp_q [$];
    int cyc = 0, rmode = 0, rcnt = 0;
    int n_out, first_pop, last_pop;
    logic prev_stall = 1'b0;
    logic [9:0] prev_out;
    logic [7:0] umem [int];
    int poll_delay = 0, polls = 0, n_cfg_w, n_cfg_h, n_start, early_rd, first_wr = -1;
    logic [31:0] wr_w = '0, wr_h = '0;
    bit arm = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        rcnt++;
        bus.m_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? (rcnt % 4 == 0 || rcnt % 4 == 3) : 1'($urandom_range(0, 1));
    end

    always @(posedge CLK) begin : unit_model
        int a;
        a = int'(bus.addra_o[ADDR_W-1:0]);
        if (bus.ena_o) begin
            if (bus.wea_o) begin
                case (bus.addra_o[ADDR_W+MODE_W-1:ADDR_W])
                    2'd0: begin
                        umem[a] = bus.dina_o[7:0];
                        if (arm) begin first_wr = a; arm = 1'b0; end
                    end
                    2'd1: begin n_start++; polls = 0; end
                    2'd2: begin n_cfg_w++; wr_w = bus.dina_o; end
                    default: begin n_cfg_h++; wr_h = bus.dina_o; end
                endcase
            end else if (bus.addra_o[ADDR_W+MODE_W-1:ADDR_W] == 2'd1) begin
                polls++;
                bus.douta_i <= (polls > poll_delay) ? 32'd1 : 32'd0;
            end else begin
                if (polls <= poll_delay) early_rd++;
                bus.douta_i <= {24'd0, ~umem[a]};
            end
        end
    end

    always @(negedge CLK) begin
        logic [7:0] e;
        if (prev_stall) check("hold", {bus.m_valid_o, bus.m_last_o, bus.m_pix_o}, prev_out);
        if (bus.m_valid_o && bus.m_ready_i) begin
            check("q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pix", bus.m_pix_o, e);
                check("last", bus.m_last_o, exp_q.size() == 0);
            end
            if (n_out == 0) first_pop = cyc;
            last_pop = cyc;
            n_out++;
        end
        prev_stall = bus.m_valid_o && !bus.m_ready_i;
        prev_out = {bus.m_valid_o, bus.m_last_o, bus.m_pix_o};
    end

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"}, bus.s_ready_o, 0);
        check({tag, "_m_valid"}, bus.m_valid_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_wea"}, bus.wea_o, 0);
        check({tag, "_ena"}, bus.ena_o, 0);
        check({tag, "_dina"}, bus.dina_o, 0);
        check({tag, "_addra"}, bus.addra_o, 0);
    endtask

    task automatic load(input int w, input int h, input int stop_at, input int bad_last);
        int n = w * h;
        int k;
        logic [7:0] pix;
        n_out = 0; n_cfg_w = 0; n_cfg_h = 0; n_start = 0; early_rd = 0; arm = 1'b1;
        @(posedge CLK); #1;
        cfg_width_i = 16'(w); cfg_height_i = 16'(h); start_i = 1'b1;
        @(posedge CLK); #1;
        start_i = 1'b0;
        for (int i = 0; i < n && i < stop_at; i++) begin
            pix = 8'(i * 37 + w + 3 * h);
            bus.s_pix_i = pix;
            bus.s_valid_i = 1'b1;
            bus.s_last_i = bad_last >= 0 ? (i == bad_last) : (i == n - 1);
            k = 0;
            @(negedge CLK);
            while (!bus.s_ready_o && k < 20) begin @(negedge CLK); k++; end
            check("load_ready", bus.s_ready_o, 1);
            exp_q.push_back(~pix);
            @(posedge CLK); #1;
        end
        bus.s_valid_i = 1'b0;
        bus.s_last_i = 1'b0;
    endtask

    task automatic finish_frame(input int w, input int h);
        int k = 0;
        while (!done_o && k < 3000) begin @(negedge CLK); k++; end
        check("done_seen", done_o, 1);
        @(negedge CLK);
        check("done_pulse", done_o, 0);
        check("busy_idle", busy_o, 0);
        check("q_empty", exp_q.size(), 0);
        check("n_out", n_out, w * h);
        check("cfg_w", wr_w, w);
        check("cfg_h", wr_h, h);
        check("n_cfg_w", n_cfg_w, 1);
        check("n_cfg_h", n_cfg_h, 1);
        check("n_start", n_start, 1);
        check("early_reads", early_rd, 0);
    endtask

    initial begin
        bus.s_pix_i = '0; bus.s_valid_i = 1'b0; bus.s_last_i = 1'b0; bus.douta_i = '0;
        repeat (3) @(negedge CLK);
        check_zero("rst");
        @(posedge CLK); #1;
        RST = 1'b1;

        rmode = 0; poll_delay = 2;
        load(4, 3, 1000, -1);
        finish_frame(4, 3);
        check("rate", last_pop - first_pop, 11);

        rmode = 1; poll_delay = 3;
        load(4, 3, 1000, -1);
        begin
            int k = 0;
            @(negedge CLK);
            while (!bus.m_valid_o && k < 500) begin @(negedge CLK); k++; end
            check("drain_valid", bus.m_valid_o, 1);
        end
        @(posedge CLK); #1;
        cfg_width_i = 16'd9; cfg_height_i = 16'd9; start_i = 1'b1;
        @(posedge CLK); #1;
        start_i = 1'b0;
        finish_frame(4, 3);

        rmode = 2; poll_delay = 50;
        load(5, 4, 1000, -1);
        finish_frame(5, 4);
        check("poll_count", polls >= 51, 1);

        rmode = 0; poll_delay = 1;
        load(20, 10, 100, -1);
        RST = 1'b0;
        #1;
        check_zero("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        first_wr = -1;
        load(4, 3, 1000, -1);
        finish_frame(4, 3);
        check("first_wr", first_wr, 0);
        check("err_default", err_o, 0);

`ifdef MEDIAN_ADAPTER_FRAME_CHECK_EN
        @(posedge CLK); #1;
        cfg_width_i = 16'd600; cfg_height_i = 16'd600; start_i = 1'b1;
        @(posedge CLK); #1;
        start_i = 1'b0;
        @(negedge CLK);
        check("big_err", err_o, 1);
        check("big_idle", busy_o, 0);
        load(4, 3, 6, 5);
        repeat (3) @(negedge CLK);
        check("last_err", err_o, 1);
        check("last_idle", busy_o, 0);
        check("last_no_cfg", n_cfg_w, 0);
        exp_q.delete();
        load(4, 3, 1000, -1);
        check("err_clear", err_o, 0);
        finish_frame(4, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
